me_result_packer: RTL and testbench

Downstream stage of the motion-estimation `core`. It consumes one `{sad_min, motion_vec_x_min, motion_vec_y_min}` result per `sad_en` pulse and tags each result with its block column/row in the frame raster. Tagged words are buffered in a small FIFO and handed to the frame-result writer over a valid/ready stream. It also accumulates the total frame SAD and flags end-of-frame.

---
 rtl/me_pkg.sv | 35 +++
 rtl/me_sync_fifo.sv | 58 +++++
 rtl/me_result_packer.sv | 138 +++++++++++++
 tb/tb_me_result_packer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/me_pkg.sv
// Shared types and word layout for the motion-estimation result path.
// Field widths, bit offsets and the packer FSM state encoding.
package me_pkg;

    localparam int SAD_W       = 14;
    localparam int MV_W        = 4;
    localparam int FRAME_SAD_W = 30;
    localparam int COL_W       = 9;
    localparam int ROW_W       = 8;
    localparam int WORD_W      = 40;

    localparam int SAD_LSB  = 0;
    localparam int LAST_BIT = 14;
    localparam int MVY_LSB  = 15;
    localparam int MVX_LSB  = 19;
    localparam int ROW_LSB  = 23;
    localparam int COL_LSB  = 31;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } me_state_e;

    // Field order matches the MSB-to-LSB word layout
    typedef struct packed {
        logic [COL_W-1:0] col;
        logic [ROW_W-1:0] row;
        logic [MV_W-1:0]  mv_x;
        logic [MV_W-1:0]  mv_y;
        logic             last;
        logic [SAD_W-1:0] sad;
    } me_word_t;

endpackage

// File: rtl/me_sync_fifo.sv
// Single-clock show-ahead FIFO; head word visible as soon as it is written.
// Full FIFO accepts a push when a pop happens in the same cycle.
module me_sync_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/me_result_packer.sv
// Tags motion-estimation results with block col/row, buffers them and
// accumulates the frame SAD; pulses frame_done after the last block.
module me_result_packer
    import me_pkg::*;
#(
    parameter int BLK_COLS   = 480,
    parameter int BLK_ROWS   = 135,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_start,
    input  logic                   sad_en,
    input  logic [SAD_W-1:0]       sad_min,
    input  logic [MV_W-1:0]        motion_vec_x_min,
    input  logic [MV_W-1:0]        motion_vec_y_min,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WORD_W-1:0]      out_data,
    output logic                   frame_done,
    output logic [FRAME_SAD_W-1:0] frame_sad,
    output logic                   overflow
);

    me_state_e        state;
    me_state_e        state_nxt;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             clear;
    logic             accept;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic             at_col_end;
    logic             at_last;
    me_word_t         word;

    assign at_col_end = (col == COL_W'(BLK_COLS - 1));
    assign at_last    = at_col_end && (row == ROW_W'(BLK_ROWS - 1));
    assign out_valid  = !empty;
    assign pop        = out_valid && out_ready;
    assign push       = accept && (!full || pop);
    assign frame_done = (state == DONE);

    always_comb begin
        state_nxt = state;
        clear     = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (frame_start) begin
                    clear     = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                // A restart outranks a coincident result strobe
                if (frame_start) begin
                    clear = 1'b1;
                end else if (sad_en) begin
                    accept = 1'b1;
                    if (at_last) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                if (frame_start) begin
                    clear     = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        word      = '0;
        word.col  = col;
        word.row  = row;
        word.mv_x = motion_vec_x_min;
        word.mv_y = motion_vec_y_min;
        word.last = at_last;
        word.sad  = sad_min;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col       <= '0;
            row       <= '0;
            frame_sad <= '0;
            overflow  <= 1'b0;
        end else if (clear) begin
            col       <= '0;
            row       <= '0;
            frame_sad <= '0;
            overflow  <= 1'b0;
        end else if (accept) begin
            // Dropped words still advance the tags and the sum
            frame_sad <= frame_sad + FRAME_SAD_W'(sad_min);
            if (!push) begin
                overflow <= 1'b1;
            end
            if (at_col_end) begin
                col <= '0;
                row <= at_last ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    me_sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (word),
        .pop   (pop),
        .rdata (out_data),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_me_result_packer.sv
// Directed and random stimulus for me_result_packer against a
// queue-based model of the frame raster and output buffer.
module tb_me_result_packer;

    localparam int COLS  = 4;
    localparam int ROWS  = 2;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start;
    logic        sad_en;
    logic [13:0] sad_min;
    logic [3:0]  mvx;
    logic [3:0]  mvy;
    logic        out_ready;
    logic        out_valid;
    logic [39:0] out_data;
    logic        frame_done;
    logic [29:0] frame_sad;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    logic [39:0] q[$];
    bit          run;
    bit          mdone;
    bit          movf;
    int          k;
    logic [29:0] msad;

    always #5 clk = ~clk;

    me_result_packer #(
        .BLK_COLS   (COLS),
        .BLK_ROWS   (ROWS),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .frame_start      (frame_start),
        .sad_en           (sad_en),
        .sad_min          (sad_min),
        .motion_vec_x_min (mvx),
        .motion_vec_y_min (mvy),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_data         (out_data),
        .frame_done       (frame_done),
        .frame_sad        (frame_sad),
        .overflow         (overflow)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [39:0] mkword(input int idx,
                                           input logic [3:0] mx,
                                           input logic [3:0] my,
                                           input logic [13:0] s);
        logic [8:0] c;
        logic [7:0] r;
        logic       l;
        c = 9'(idx % COLS);
        r = 8'(idx / COLS);
        l = (idx == COLS * ROWS - 1);
        return {c, r, mx, my, l, s};
    endfunction

    task automatic model_reset();
        q.delete();
        run   = 0;
        mdone = 0;
        movf  = 0;
        k     = 0;
        msad  = '0;
    endtask

    task automatic model_edge();
        bit          pop;
        bit          fits;
        logic [39:0] w;
        pop   = (q.size() > 0) && out_ready;
        fits  = (q.size() < DEPTH) || pop;
        mdone = 0;
        if (pop) begin
            w = q.pop_front();
        end
        if (frame_start) begin
            run  = 1;
            k    = 0;
            msad = '0;
            movf = 0;
        end else if (run && sad_en) begin
            msad = msad + 30'(sad_min);
            if (fits) begin
                q.push_back(mkword(k, mvx, mvy, sad_min));
            end else begin
                movf = 1;
            end
            k++;
            if (k == COLS * ROWS) begin
                run   = 0;
                mdone = 1;
                k     = 0;
            end
        end
    endtask

    task automatic compare_all();
        chk("valid", out_valid, q.size() > 0);
        if (q.size() > 0) begin
            chk("data", out_data, q[0]);
        end else begin
            chk("data_idle", out_data, 0);
        end
        chk("done", frame_done, mdone);
        chk("fsad", frame_sad, msad);
        chk("ovf", overflow, movf);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic drive(input bit fs, input bit en, input int s,
                         input int mx, input int my, input bit rdy);
        frame_start = fs;
        sad_en      = en;
        sad_min     = 14'(s);
        mvx         = 4'(mx);
        mvy         = 4'(my);
        out_ready   = rdy;
        tick();
    endtask

    initial begin
        logic [39:0] w0;
        int          n;
        rst         = 1'b0;
        frame_start = 1'b0;
        sad_en      = 1'b0;
        sad_min     = '0;
        mvx         = '0;
        mvy         = '0;
        out_ready   = 1'b0;
        model_reset();
        #12;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_fsad", frame_sad, 0);
        chk("rst_ovf", overflow, 0);
        rst = 1'b1;

        // idle: strobes without frame_start are ignored
        for (int i = 0; i < 3; i++) drive(0, 1, 5 + i, 1, 2, 1);
        chk("idle_valid", out_valid, 0);

        // full frame, consumer always ready
        drive(1, 0, 0, 0, 0, 1);
        for (int i = 1; i <= 8; i++) begin
            drive(0, 1, i, 3, 12, 1);
            chk("f1_word", out_data, mkword(i - 1, 4'd3, 4'd12, 14'(i)));
            chk("f1_last", out_data[14], i == 8);
            chk("f1_done", frame_done, i == 8);
        end
        chk("f1_sad", frame_sad, 36);
        drive(0, 0, 0, 0, 0, 1);
        chk("f1_done_clr", frame_done, 0);
        chk("f1_sad_hold", frame_sad, 36);

        // back-pressure with overflow
        drive(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            drive(0, 1, 100, 5, 6, 0);
            if (i == 0) w0 = out_data;
        end
        chk("bp_hold", out_data, w0);
        chk("bp_ovf", overflow, 1);
        for (int j = 0; j < 4; j++) begin
            frame_start = 0;
            sad_en      = 0;
            out_ready   = 1;
            chk("bp_col", out_data[39:31], j);
            chk("bp_row", out_data[30:23], 0);
            tick();
        end
        chk("bp_empty", out_valid, 0);
        drive(0, 1, 100, 5, 6, 1);
        chk("bp_tag7_col", out_data[39:31], 2);
        chk("bp_tag7_row", out_data[30:23], 1);
        chk("bp_sad", frame_sad, 700);

        // full FIFO: push with simultaneous pop must not drop
        drive(1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) drive(0, 1, 7 + i, 1, 1, 0);
        drive(0, 1, 20, 1, 1, 1);
        chk("pp_ovf", overflow, 0);
        drive(0, 0, 0, 0, 0, 0);
        n = 0;
        while (out_valid && n < 10) begin
            drive(0, 0, 0, 0, 0, 1);
            n++;
        end
        chk("pp_occ", n, 4);

        // restart mid-frame
        drive(1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) drive(0, 1, 9, 2, 2, 1);
        drive(1, 0, 0, 0, 0, 1);
        drive(0, 1, 55, 2, 2, 1);
        chk("rs_col", out_data[39:31], 0);
        chk("rs_row", out_data[30:23], 0);
        chk("rs_sad", frame_sad, 55);
        drive(1, 1, 77, 2, 2, 1);
        chk("rs_nopush", out_valid, 0);
        chk("rs_sad0", frame_sad, 0);

        // asynchronous reset mid-frame
        drive(0, 1, 11, 1, 1, 0);
        drive(0, 1, 12, 1, 1, 0);
        chk("ar_pre", out_valid, 1);
        rst = 1'b0;
        #1;
        model_reset();
        chk("ar_valid", out_valid, 0);
        chk("ar_fsad", frame_sad, 0);
        #2;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) drive(0, 1, 3, 1, 1, 1);
        chk("ar_ignore", out_valid, 0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 39) == 0,
                  $urandom_range(0, 9) < 7,
                  int'($urandom_range(0, 16383)),
                  int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 15)),
                  $urandom_range(0, 9) < 6);
            if (!run && !mdone && $urandom_range(0, 3) == 0) begin
                drive(1, 0, 0, 0, 0, 1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
